// File: rtl/id_stage.sv
// id_stage: registered, handshaked MIPS decode stage with load-use bubble insertion and saturating bubble counter
module id_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int HAZARD_EN = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc_plus4,
  input  logic [31:0]           in_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc_plus4,
  output logic [4:0]            reg1_addr,
  output logic [4:0]            reg2_addr,
  output logic [4:0]            rt,
  output logic [4:0]            rd,
  output logic [DATA_WIDTH-1:0] imm_signed,
  output logic [DATA_WIDTH-1:0] imm_unsigned,
  output logic [DATA_WIDTH-1:0] shamt,
  output logic [5:0]            opcode,
  output logic [5:0]            funct,
  output logic                  is_load,
  output logic [CNT_WIDTH-1:0]  bubble_cnt
);
  logic [31:0] inst;
  logic hazard, accept;
  assign reg1_addr = inst[25:21];
  assign reg2_addr = inst[20:16];
  assign rt = inst[20:16];
  assign rd = inst[15:11];
  assign imm_signed = {{(DATA_WIDTH-16){inst[15]}}, inst[15:0]};
  assign imm_unsigned = DATA_WIDTH'(inst[15:0]);
  assign shamt = DATA_WIDTH'(inst[10:6]);
  assign opcode = inst[31:26];
  assign funct = inst[5:0];
  assign is_load = opcode inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  assign hazard = (HAZARD_EN != 0) && out_valid && is_load && rt != 5'd0 && in_valid &&
                  (in_inst[25:21] == rt || in_inst[20:16] == rt);
  assign in_ready = flush || ((!out_valid || out_ready) && !hazard);
  assign accept = in_valid && in_ready && !flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc_plus4 <= '0;
      inst <= '0;
      bubble_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc_plus4 <= in_pc_plus4;
      inst <= in_inst;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      if (hazard && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: table, directed and random checks of id_stage against a cycle-level reference model
module tb_id_stage;
  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc_plus4;
  always #5 clk = ~clk;

  typedef struct packed {
    logic ir, ov, il;
    logic [31:0] pc;
    logic [4:0] r1, r2, rt, rd;
    logic [63:0] is, iu, sh;
    logic [5:0] op, fn;
    logic [15:0] bc;
  } obs_t;
  obs_t obs[3];

  for (genvar g = 0; g < 3; g++) begin : d
    localparam int DW = g == 2 ? 64 : 32;
    localparam int CW = g == 2 ? 2 : 16;
    logic ir, ov, il;
    logic [31:0] pc;
    logic [4:0] r1, r2, rt, rd;
    logic [DW-1:0] is, iu, sh;
    logic [5:0] op, fn;
    logic [CW-1:0] bc;
    id_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .HAZARD_EN(g == 1 ? 0 : 1), .CNT_WIDTH(CW)) u (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir),
      .in_pc_plus4(in_pc_plus4), .in_inst(in_inst), .out_valid(ov), .out_ready(out_ready),
      .out_pc_plus4(pc), .reg1_addr(r1), .reg2_addr(r2), .rt(rt), .rd(rd),
      .imm_signed(is), .imm_unsigned(iu), .shamt(sh), .opcode(op), .funct(fn),
      .is_load(il), .bubble_cnt(bc)
    );
    assign obs[g] = {ir, ov, il, pc, r1, r2, rt, rd, 64'(is), 64'(iu), 64'(sh), op, fn, 16'(bc)};
  end

  int total = 0, passed = 0;
  bit live = 0;
  logic mv[3];
  logic [31:0] mi[3], mp[3];
  int mc[3];
  int hz[3] = '{1, 0, 1};
  int cm[3] = '{65535, 65535, 3};

  task automatic chk(string n, int g, logic [63:0] a, logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", n, g, a, e);
  endtask

  function automatic bit m_load(logic [31:0] w);
    return w[31:26] inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic bit m_haz(int g);
    logic [4:0] t = mi[g][20:16];
    return hz[g] != 0 && mv[g] && m_load(mi[g]) && t != 0 && in_valid &&
           (in_inst[25:21] == t || in_inst[20:16] == t);
  endfunction

  function automatic bit m_ready(int g);
    return flush || ((!mv[g] || out_ready) && !m_haz(g));
  endfunction

  task automatic cycle();
    logic nv[3];
    logic [31:0] ni[3], np[3];
    int nc[3];
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      logic [63:0] m = g == 2 ? '1 : 64'hFFFF_FFFF;
      if (live) begin
        chk("in_ready", g, obs[g].ir, m_ready(g));
        chk("out_valid", g, obs[g].ov, mv[g]);
        chk("pc", g, obs[g].pc, mp[g]);
        chk("reg1", g, obs[g].r1, mi[g][25:21]);
        chk("reg2", g, obs[g].r2, mi[g][20:16]);
        chk("rt", g, obs[g].rt, mi[g][20:16]);
        chk("rd", g, obs[g].rd, mi[g][15:11]);
        chk("imm_s", g, obs[g].is, 64'($signed(mi[g][15:0])) & m);
        chk("imm_u", g, obs[g].iu, 64'(mi[g][15:0]));
        chk("shamt", g, obs[g].sh, 64'(mi[g][10:6]));
        chk("opcode", g, obs[g].op, mi[g][31:26]);
        chk("funct", g, obs[g].fn, mi[g][5:0]);
        chk("is_load", g, obs[g].il, m_load(mi[g]));
        chk("bubble_cnt", g, obs[g].bc, mc[g]);
      end
      nv[g] = mv[g]; ni[g] = mi[g]; np[g] = mp[g]; nc[g] = mc[g];
      if (rst) begin
        nv[g] = 0; ni[g] = 0; np[g] = 0; nc[g] = 0;
      end else if (flush) nv[g] = 0;
      else if (in_valid && m_ready(g)) begin
        nv[g] = 1; ni[g] = in_inst; np[g] = in_pc_plus4;
      end else if (out_ready) begin
        nv[g] = 0;
        if (m_haz(g)) nc[g] = mc[g] + 1 > cm[g] ? cm[g] : mc[g] + 1;
      end
    end
    @(posedge clk);
    for (int g = 0; g < 3; g++) begin
      mv[g] = nv[g]; mi[g] = ni[g]; mp[g] = np[g]; mc[g] = nc[g];
    end
    #1;
  endtask

  task automatic drive(bit r, bit f, bit v, bit o, logic [31:0] i, logic [31:0] p);
    rst = r; flush = f; in_valid = v; out_ready = o; in_inst = i; in_pc_plus4 = p;
  endtask

  typedef struct {
    bit r, f, v, o;
    logic [31:0] inst, pc;
    bit chk, ev, er;
    int ec;
  } vec_t;
  vec_t tbl[16];
  localparam logic [31:0] ADDI = 32'h2128FFFC, LW = 32'h8D280000, ADD = 32'h010B5020;

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 0};
    tbl[2]  = '{0, 0, 1, 1, ADDI, 32'h4, 1, 0, 1, 0};
    tbl[3]  = '{0, 0, 1, 0, LW, 32'h8, 1, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, LW, 32'h8, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, LW, 32'h8, 1, 1, 0, 0};
    tbl[6]  = '{0, 0, 1, 1, LW, 32'h8, 1, 1, 1, 0};
    tbl[7]  = '{0, 0, 1, 1, ADD, 32'hC, 1, 1, 0, 0};
    tbl[8]  = '{0, 0, 1, 1, ADD, 32'hC, 1, 0, 1, 1};
    tbl[9]  = '{0, 0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 1};
    tbl[10] = '{0, 1, 1, 0, 32'h3C01ABCD, 32'h10, 1, 1, 1, 1};
    tbl[11] = '{0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1, 1};
    tbl[12] = '{0, 0, 1, 1, LW, 32'h14, 1, 0, 1, 1};
    tbl[13] = '{0, 0, 1, 0, ADD, 32'h18, 1, 1, 0, 1};
    tbl[14] = '{0, 1, 1, 1, ADD, 32'h18, 1, 1, 1, 1};
    tbl[15] = '{0, 0, 0, 1, 32'h0, 32'h0, 1, 0, 1, 1};
    for (int r = 0; r < 16; r++) begin
      drive(tbl[r].r, tbl[r].f, tbl[r].v, tbl[r].o, tbl[r].inst, tbl[r].pc);
      live = r > 0;
      #1;
      if (tbl[r].chk) begin
        chk("tbl_out_valid", r, obs[0].ov, tbl[r].ev);
        chk("tbl_in_ready", r, obs[0].ir, tbl[r].er);
        chk("tbl_bubble_cnt", r, obs[0].bc, tbl[r].ec);
      end
      if (r == 3) begin
        chk("addi_reg1", 0, obs[0].r1, 9);
        chk("addi_rt", 0, obs[0].rt, 8);
        chk("addi_opcode", 0, obs[0].op, 8);
        chk("addi_imm_s", 0, obs[0].is, 64'hFFFFFFFC);
        chk("addi_imm_u", 0, obs[0].iu, 64'h0000FFFC);
        chk("addi_is_load", 0, obs[0].il, 0);
      end
      if (r == 8) begin
        chk("nohaz_valid", 1, obs[1].ov, 1);
        chk("nohaz_rd", 1, obs[1].rd, 10);
      end
      if (r == 9) begin
        chk("add_rd", 0, obs[0].rd, 10);
        chk("add_funct", 0, obs[0].fn, 6'h20);
      end
      cycle();
    end
    drive(0, 0, 1, 1, 32'h24008000, 32'h20);
    cycle();
    drive(0, 0, 1, 1, 32'h000007C0, 32'h24);
    #1;
    chk("w64_imm_s", 2, obs[2].is, 64'hFFFFFFFFFFFF8000);
    chk("w64_imm_u", 2, obs[2].iu, 64'h8000);
    cycle();
    drive(0, 0, 0, 1, 32'h0, 32'h0);
    #1;
    chk("w64_shamt", 2, obs[2].sh, 31);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 1, LW, 32'h100);
      cycle();
      drive(0, 0, 1, 1, ADD, 32'h104);
      cycle();
      cycle();
    end
    drive(0, 0, 0, 1, 32'h0, 32'h0);
    cycle();
    chk("cnt_total", 0, obs[0].bc, 6);
    chk("cnt_nohaz", 1, obs[1].bc, 0);
    chk("cnt_sat", 2, obs[2].bc, 3);
    for (int k = 0; k < 400; k++) begin
      logic [5:0] ops[6] = '{6'h23, 6'h20, 6'h24, 6'h00, 6'h08, 6'h2B};
      logic [31:0] w = $urandom;
      w[31:26] = ops[$urandom_range(0, 5)];
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, w, $urandom);
      cycle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
